// File: rtl/encode_job_sched.sv
// Round-robin job scheduler sharing one 8-bit encode engine.
// One job in flight; engine start/data sequenced with fixed timing.
module encode_job_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  output logic               eng_start,
  output logic [7:0]         eng_data,
  input  logic [7:0]         eng_result,
  input  logic               eng_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_id,
  output logic [7:0]         rsp_result,
  output logic [7:0]         rsp_echo,
  output logic               rsp_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_OPA,
    S_OPB,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]    ptr;
  logic [2:0]    gnt_id;
  logic [2:0]    hi_id;
  logic [2:0]    lo_id;
  logic          hi_any;
  logic          lo_any;
  logic          gnt_any;
  logic [7:0]    a_sel;
  logic [7:0]    b_sel;
  logic [7:0]    a_q;
  logic [7:0]    b_q;
  logic [7:0]    cap_q;
  logic [2:0]    id_q;
  logic [CW-1:0] cnt;
  logic          tmo;
  logic          take;

  // hi_*: first valid at or above ptr; lo_*: first valid overall (wrap)
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_any = 1'b1;
        lo_id  = 3'(i);
        if (3'(i) >= ptr) begin
          hi_any = 1'b1;
          hi_id  = 3'(i);
        end
      end
    end
    gnt_any = hi_any | lo_any;
    gnt_id  = hi_any ? hi_id : lo_id;
    a_sel   = '0;
    b_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == 3'(i)) begin
        a_sel = req_a[8*i +: 8];
        b_sel = req_b[8*i +: 8];
      end
    end
  end

  assign take = (state == S_IDLE) && gnt_any;
  assign tmo  = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      cap_q      <= '0;
      cnt        <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_echo   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        a_q  <= a_sel;
        b_q  <= b_sel;
        id_q <= gnt_id;
        ptr  <= (gnt_id == 3'(N_REQ - 1)) ?
                '0 : gnt_id + 3'd1;
      end
      if (state == S_OPB) begin
        cnt <= '0;
      end
      if (state == S_WAIT) begin
        cap_q <= eng_result;
        cnt   <= cnt + CW'(1);
        // done on the last WAIT cycle still wins over timeout
        if (eng_done) begin
          rsp_id     <= id_q;
          rsp_result <= cap_q;
          rsp_echo   <= eng_result;
          rsp_err    <= 1'b0;
        end else if (tmo) begin
          rsp_id     <= id_q;
          rsp_result <= '0;
          rsp_echo   <= '0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (gnt_any) state_nx = S_START;
      S_START: state_nx = S_OPA;
      S_OPA:   state_nx = S_OPB;
      S_OPB:   state_nx = S_WAIT;
      S_WAIT:  if (eng_done || tmo) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ready is masked during reset so no handshake can be lost
  always_comb begin
    req_ready = '0;
    if (take && rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_ready[i] = (gnt_id == 3'(i));
      end
    end
    eng_start = (state == S_START);
    rsp_valid = (state == S_RESP);
    eng_data  = '0;
    unique case (1'b1)
      (state == S_OPA): eng_data = a_q;
      (state == S_OPB): eng_data = b_q;
      default:          eng_data = '0;
    endcase
  end

endmodule
